// File: rtl/encoder8x3_drain.sv
// Sequential 8-to-3 encoder: captures a request vector and emits the index of each set bit,
// lowest first, one per output handshake. Define ENC8_COUNT_EN to add the out_count popcount port.
module encoder8x3_drain (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_vec,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_code,
   output logic       out_last,
   output logic       busy
`ifdef ENC8_COUNT_EN
   ,
   output logic [3:0] out_count
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t     state_r;
   state_t     state_next_s;
   logic [7:0] pend_r;

   function automatic logic [2:0] lowest_index(input logic [7:0] v);
      logic [2:0] idx;
      casez (v)
         8'b???????1: idx = 3'd0;
         8'b??????10: idx = 3'd1;
         8'b?????100: idx = 3'd2;
         8'b????1000: idx = 3'd3;
         8'b???10000: idx = 3'd4;
         8'b??100000: idx = 3'd5;
         8'b?1000000: idx = 3'd6;
         8'b10000000: idx = 3'd7;
         default:     idx = 3'd0;
      endcase
      return idx;
   endfunction

   function automatic logic is_single_bit(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

`ifdef ENC8_COUNT_EN
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'd0, v[i]};
      end
      return cnt;
   endfunction
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; a zero vector is accepted and dropped without leaving IDLE
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid && (in_vec != 8'd0)) begin
               state_next_s = ST_DRAIN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (out_ready && is_single_bit(pend_r)) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Output decode from registered state and pending bits only
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_code  = lowest_index(pend_r);
      out_last  = is_single_bit(pend_r);
      case (state_r)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_DRAIN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   // Pending-bit register: load on acceptance, clear the lowest set bit on each output handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid && (in_vec != 8'd0)) begin
                  pend_r <= in_vec;
               end else begin
                  pend_r <= pend_r;
               end
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  pend_r <= pend_r & (pend_r - 8'd1);
               end else begin
                  pend_r <= pend_r;
               end
            end
            default: pend_r <= 8'd0;
         endcase
      end
   end

`ifdef ENC8_COUNT_EN
   logic [3:0] count_r;

   // Popcount register: captured on acceptance, held through the drain, cleared on return to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= 4'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid && (in_vec != 8'd0)) begin
                  count_r <= popcount8(in_vec);
               end else begin
                  count_r <= 4'd0;
               end
            end
            ST_DRAIN: begin
               if (out_ready && is_single_bit(pend_r)) begin
                  count_r <= 4'd0;
               end else begin
                  count_r <= count_r;
               end
            end
            default: count_r <= 4'd0;
         endcase
      end
   end

   assign out_count = count_r;
`endif

endmodule

// File: tb/tb_encoder8x3_drain.sv
// Scoreboard bench for encoder8x3_drain: stimulus pushes expected codes, a negedge monitor pops them.
module tb_encoder8x3_drain;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_vec = 8'd0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [2:0] out_code;
   logic       out_last;
   logic       busy;
`ifdef ENC8_COUNT_EN
   logic [3:0] out_count;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] code;
      logic       last;
      logic [3:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   encoder8x3_drain dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_last  (out_last),
      .busy      (busy)
`ifdef ENC8_COUNT_EN
      ,
      .out_count (out_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: one entry per set bit, ascending, last flag on the highest set bit
   task automatic push_expected(input logic [7:0] v);
      int   k;
      int   seen;
      exp_t e;
      k = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) k++;
      end
      for (int i = 0; i < 8; i++) begin
         if (v[i]) begin
            seen++;
            e.code = 3'(i);
            e.last = (seen == k);
            e.cnt  = 4'(k);
            exp_q.push_back(e);
         end
      end
   endtask

   // Monitor: compare each output handshake against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         check("busy_eq_valid", int'(busy), int'(out_valid));
         check("ready_eq_not_valid", int'(in_ready), int'(!out_valid));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_code actual=%0d required=none at %0t", out_code, $time);
            end else begin
               e = exp_q.pop_front();
               check("code", int'(out_code), int'(e.code));
               check("last", int'(out_last), int'(e.last));
`ifdef ENC8_COUNT_EN
               check("count", int'(out_count), int'(e.cnt));
`endif
            end
         end
      end
   end

   // Present a vector for exactly one rising edge; returns at edge+1
   task automatic send(input logic [7:0] v);
      push_expected(v);
      in_valid = 1'b1;
      in_vec   = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_vec   = 8'd0;
   endtask

   // Count cycles until in_ready returns, with a bound
   task automatic drain_cycles(output int n);
      n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic wait_idle_random(input string name);
      int n;
      n = 0;
      while (!(in_ready && exp_q.size() == 0) && n < 400) begin
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         n++;
      end
      out_ready = 1'b1;
      check({name, "_idle"}, int'(in_ready), 1);
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_in_ready"}, int'(in_ready), 1);
      check({name, "_out_valid"}, int'(out_valid), 0);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_out_code"}, int'(out_code), 0);
      check({name, "_out_last"}, int'(out_last), 0);
`ifdef ENC8_COUNT_EN
      check({name, "_out_count"}, int'(out_count), 0);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;

      // Reset then idle
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      rst_n = 1'b1;
      #1;
      check_reset_outputs("rst_release");

      // Single bit, accepted on the first edge after reset release
      out_ready = 1'b1;
      send(8'b0010_0000);
      check("single_valid", int'(out_valid), 1);
      check("single_code", int'(out_code), 5);
      check("single_last", int'(out_last), 1);
      @(posedge clk);
      #1;
      check("single_ready_after", int'(in_ready), 1);

      // Multi-bit with two stall cycles
      out_ready = 1'b0;
      send(8'b1000_1010);
      for (int s = 0; s < 2; s++) begin
         check("stall_valid", int'(out_valid), 1);
         check("stall_code", int'(out_code), 1);
         check("stall_last", int'(out_last), 0);
`ifdef ENC8_COUNT_EN
         check("stall_count", int'(out_count), 3);
`endif
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      drain_cycles(n);
      check("bp_drain_cycles", n, 3);

      // Zero vector is swallowed
      in_valid = 1'b1;
      in_vec   = 8'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("zero_out_valid", int'(out_valid), 0);
      check("zero_in_ready", int'(in_ready), 1);

      // All ones: eight consecutive codes 0..7
      send(8'hFF);
      drain_cycles(n);
      check("ff_drain_cycles", n, 8);
      check("ff_drained", exp_q.size(), 0);

      // All 256 vectors, random backpressure
      for (int v = 0; v < 256; v++) begin
         out_ready = 1'($urandom_range(0, 1));
         send(8'(v));
         wait_idle_random("sweep");
      end

      // Reset in the middle of a drain
      out_ready = 1'b1;
      send(8'hF0);
      check("mid_first_code", int'(out_code), 4);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("mid_release_ready", int'(in_ready), 1);
      repeat (10) @(posedge clk);
      #1;
      check("mid_no_resume", int'(out_valid), 0);

      check("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
